adder8_reg: RTL and testbench

//   8-bit binary adder with carry-in, carry-out and signed-overflow flag, registered at the output.

---
 rtl/adder8_reg.sv | 106 ++++++++++
 tb/tb_adder8_reg.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder8_reg.sv
// ---------------------------------------------------------------------------
// adder8_reg -- 8-bit ripple-carry adder with carry-in, carry-out and signed
// overflow flag, registered at the output with a valid qualifier.
//
// The datapath is an explicit chain of one-bit full-adder cells.
// The result appears one clock after the operands are presented.
// There is no backpressure: every cycle with in_valid=1 yields exactly one
// cycle with out_valid=1 on the following cycle.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active low (0 = in reset)
//   in_valid   in   1      a/b/cin are valid this cycle
//   a          in   WIDTH  operand A (unsigned or two's complement)
//   b          in   WIDTH  operand B (unsigned or two's complement)
//   cin        in   1      carry-in, bit-0 weight
//   out_valid  out  1      sum/cout/ovf hold a new result this cycle
//   sum        out  WIDTH  (a + b + cin) mod 2**WIDTH
//   cout       out  1      carry out of the top bit (unsigned overflow)
//   ovf        out  1      signed overflow: carry into top bit ^ carry out
// ---------------------------------------------------------------------------

// One-bit full-adder cell used to build the ripple chain.
module adder8_reg_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    // Propagate term is shared by the sum and the carry.
    assign p  = x ^ y;
    assign s  = p ^ ci;
    assign co = (x & y) | (ci & p);
endmodule

module adder8_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    // Stage p0: combinational ripple-carry core
    logic [WIDTH:0]   carry_p0;
    logic [WIDTH-1:0] sum_p0;
    logic             cout_p0;
    logic             ovf_p0;

    assign carry_p0[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        adder8_reg_fa u_fa (
            .x  (a[i]),
            .y  (b[i]),
            .ci (carry_p0[i]),
            .s  (sum_p0[i]),
            .co (carry_p0[i+1])
        );
    end

    assign cout_p0 = carry_p0[WIDTH];
    // Signed overflow is detected where the carry into the sign bit differs
    // from the carry out of it.
    assign ovf_p0  = carry_p0[WIDTH-1] ^ carry_p0[WIDTH];

    // Stage p1: output register
    logic             vld_p1;
    logic [WIDTH-1:0] sum_p1;
    logic             cout_p1;
    logic             ovf_p1;

    // The result registers load only on valid cycles, so operands that are
    // don't-care (possibly X) while in_valid=0 never reach the outputs, and
    // the last result is held. Reset clears data as well as valid so that a
    // result in flight is discarded and the outputs read zero in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            sum_p1  <= '0;
            cout_p1 <= 1'b0;
            ovf_p1  <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sum_p1  <= sum_p0;
                cout_p1 <= cout_p0;
                ovf_p1  <= ovf_p0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign sum       = sum_p1;
    assign cout      = cout_p1;
    assign ovf       = ovf_p1;
endmodule

// File: tb/tb_adder8_reg.sv
// ---------------------------------------------------------------------------
// tb_adder8_reg -- self-checking bench for adder8_reg.
// Expected results are pushed to a scoreboard queue as {cout, ovf, sum}
// when a valid vector is driven and popped one clock later.
// ---------------------------------------------------------------------------
module tb_adder8_reg;
    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int checks = 0;
    int passed = 0;

    logic [9:0] sb[$];

    adder8_reg #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 9-bit arithmetic sum; signed overflow when both operands
    // share a sign and the result sign differs.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic ci);
        logic [8:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {8'b0, ci};
        v = (x[7] == y[7]) && (t[7] != x[7]);
        return {t[8], v, t[7:0]};
    endfunction

    task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic ci,
                         input logic [9:0] exp);
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = ci;
        sb.push_back(exp);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b1;
        a = 8'h55;
        b = 8'h55;
        cin = 1'b0;
        #2;
        checks++;
        if ({out_valid, cout, ovf, sum} !== 11'b0)
            $display("FAIL reset_between_edges: got v=%b c=%b o=%b s=%h want all 0",
                     out_valid, cout, ovf, sum);
        else passed++;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, cout, ovf, sum} !== 11'b0)
                $display("FAIL reset_after_edge: got v=%b c=%b o=%b s=%h want all 0",
                         out_valid, cout, ovf, sum);
            else passed++;
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [9:0] exp;
        drive(8'h12, 8'h34, 1'b0, {1'b0, 1'b0, 8'h46});
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        checks++;
        if ({out_valid, cout, ovf, sum} !== {1'b1, exp})
            $display("FAIL basic_latency: got v=%b c=%b o=%b s=%h want v=1 %h",
                     out_valid, cout, ovf, sum, exp);
        else passed++;
    endtask

    task automatic test_carry_ovf();
        logic [9:0] exp;
        logic [7:0] va[4];
        logic [7:0] vb[4];
        logic       vc[4];
        logic [9:0] ve[4];
        va = '{8'hFF, 8'hFF, 8'h7F, 8'h80};
        vb = '{8'h01, 8'hFF, 8'h01, 8'h80};
        vc = '{1'b0, 1'b1, 1'b0, 1'b0};
        ve = '{{1'b1, 1'b0, 8'h00}, {1'b1, 1'b0, 8'hFF},
               {1'b0, 1'b1, 8'h80}, {1'b1, 1'b1, 8'h00}};
        for (int i = 0; i < 4; i++) begin
            drive(va[i], vb[i], vc[i], ve[i]);
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            checks++;
            if ({out_valid, cout, ovf, sum} !== {1'b1, exp})
                $display("FAIL carry_ovf_%0d: got v=%b c=%b o=%b s=%h want v=1 %h",
                         i, out_valid, cout, ovf, sum, exp);
            else passed++;
        end
        // Wrap-around with carry-in.
        drive(8'hFF, 8'h00, 1'b1, {1'b1, 1'b0, 8'h00});
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        checks++;
        if ({out_valid, cout, ovf, sum} !== {1'b1, exp})
            $display("FAIL wrap_cin: got v=%b c=%b o=%b s=%h want v=1 %h",
                     out_valid, cout, ovf, sum, exp);
        else passed++;
    endtask

    task automatic test_hold();
        logic [9:0] exp;
        drive(8'h01, 8'h02, 1'b0, {1'b0, 1'b0, 8'h03});
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        checks++;
        if ({out_valid, cout, ovf, sum} !== {1'b1, exp})
            $display("FAIL hold_load: got v=%b c=%b o=%b s=%h want v=1 %h",
                     out_valid, cout, ovf, sum, exp);
        else passed++;
        in_valid = 1'b0;
        a = 8'hAA;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, cout, ovf, sum} !== {1'b0, exp})
            $display("FAIL hold_invalid: got v=%b c=%b o=%b s=%h want v=0 %h",
                     out_valid, cout, ovf, sum, exp);
        else passed++;
        a = 8'hxx;
        b = 8'hxx;
        cin = 1'bx;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, cout, ovf, sum} !== {1'b0, exp})
            $display("FAIL hold_x_inputs: got v=%b c=%b o=%b s=%h want v=0 %h",
                     out_valid, cout, ovf, sum, exp);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp;
        logic [7:0] x;
        logic [7:0] y;
        logic       ci;
        int         errs;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            x  = 8'($urandom_range(0, 255));
            y  = 8'($urandom_range(0, 255));
            ci = 1'($urandom_range(0, 1));
            drive(x, y, ci, model(x, y, ci));
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            checks++;
            if ({out_valid, cout, ovf, sum} !== {1'b1, exp}) begin
                if (errs < 10)
                    $display("FAIL stream_%0d: a=%h b=%h cin=%b got v=%b c=%b o=%b s=%h want v=1 %h",
                             i, x, y, ci, out_valid, cout, ovf, sum, exp);
                errs++;
            end else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp;
        drive(8'h3C, 8'h41, 1'b1, {1'b0, 1'b0, 8'h7E});
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        checks++;
        if ({out_valid, cout, ovf, sum} !== {1'b1, exp})
            $display("FAIL midrst_pre: got v=%b c=%b o=%b s=%h want v=1 %h",
                     out_valid, cout, ovf, sum, exp);
        else passed++;
        // A second vector is presented but reset lands before it is sampled.
        a = 8'h90;
        b = 8'h90;
        cin = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, cout, ovf, sum} !== 11'b0)
            $display("FAIL midrst_immediate: got v=%b c=%b o=%b s=%h want all 0",
                     out_valid, cout, ovf, sum);
        else passed++;
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, cout, ovf, sum} !== 11'b0)
            $display("FAIL midrst_post_release: got v=%b c=%b o=%b s=%h want all 0",
                     out_valid, cout, ovf, sum);
        else passed++;
        drive(8'h10, 8'h20, 1'b0, {1'b0, 1'b0, 8'h30});
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        checks++;
        if ({out_valid, cout, ovf, sum} !== {1'b1, exp})
            $display("FAIL midrst_recover: got v=%b c=%b o=%b s=%h want v=1 %h",
                     out_valid, cout, ovf, sum, exp);
        else passed++;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        a = 8'h00;
        b = 8'h00;
        cin = 1'b0;
        test_reset();
        @(posedge clk);
        #1;
        test_basic();
        test_carry_ovf();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
